dotp_seq: RTL and testbench

Dot-product sequencer that drives one shared 64x64 MAC pipeline (3 register stages: product, acc_in add, output). It accepts a start command with a vector length and a 64-bit bias, streams operand pairs into the MAC at one pair per cycle, and tags each issue. Returned MAC outputs are summed into a 128-bit result, which is presented on a valid/ready result port. It sits between the operand-fetch logic and the MAC instance.

---
 rtl/dotp_if.sv | 49 ++++
 rtl/dotp_seq.sv | 153 +++++++++++++++
 tb/tb_dotp_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dotp_if.sv
// ---------------------------------------------------------------------------
// dotp_if
// Bundles the command, operand, MAC and result signals of the dot-product
// sequencer so they can be passed as a single port.
//
// Signals:
//   start, len, bias          command strobe, vector length, bias
//   busy                      sequencer not idle
//   op_valid, op_ready        operand pair handshake
//   op_a, op_b                operand pair
//   mac_a, mac_b, mac_acc_in  drive into the shared MAC pipeline
//   mac_acc_out               registered output of the MAC
//   res_valid, res_ready      result handshake
//   res_data, res_ovf         128-bit result and sticky saturation flag
//
// Modports:
//   slave   the dotp_seq view
//   master  the surrounding logic (operand fetch, MAC, result consumer)
// ---------------------------------------------------------------------------
interface dotp_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [63:0]      bias;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic [63:0]      op_a;
    logic [63:0]      op_b;
    logic [63:0]      mac_a;
    logic [63:0]      mac_b;
    logic [63:0]      mac_acc_in;
    logic [127:0]     mac_acc_out;
    logic             res_valid;
    logic             res_ready;
    logic [127:0]     res_data;
    logic             res_ovf;

    modport slave (
        input  start, len, bias, op_valid, op_a, op_b, mac_acc_out, res_ready,
        output busy, op_ready, mac_a, mac_b, mac_acc_in, res_valid, res_data, res_ovf
    );

    modport master (
        output start, len, bias, op_valid, op_a, op_b, mac_acc_out, res_ready,
        input  busy, op_ready, mac_a, mac_b, mac_acc_in, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/dotp_seq.sv
// ---------------------------------------------------------------------------
// dotp_seq
// Dot-product sequencer in front of a shared 64x64 MAC pipeline. A start
// command latches a vector length and a 64-bit bias, operand pairs are issued
// to the MAC one per cycle, and each issue carries a tag down a shadow
// pipeline so the returning MAC outputs can be summed into a 128-bit result.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   dotp_if.slave (command, operands, MAC side, result side)
//
// Parameters:
//   LEN_W    width of the vector length
//   MAC_LAT  register stages in the attached MAC (a/b sampled to acc_out)
//
// Build option:
//   DOTP_SAT_EN  when defined the accumulator saturates at 2^128-1 and
//                res_ovf records a carry out; otherwise the sum wraps and
//                res_ovf stays 0.
// ---------------------------------------------------------------------------
module dotp_seq #(
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 3
) (
    input logic   clk,
    input logic   rst,
    dotp_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [63:0]      r_bias;
    logic [63:0]      r_mac_a;
    logic [63:0]      r_mac_b;
    logic [127:0]     r_acc;
    logic             r_ovf;
    logic             r_first_pending;
    // Stage 0 lines up with mac_a/mac_b, stage 1 with the product register,
    // stage MAC_LAT with acc_out.
    logic [MAC_LAT:0] r_tag_valid;
    logic [MAC_LAT:0] r_tag_first;

    logic             w_hs;
    logic             w_last;
    logic             w_pipe_empty;
    logic [127:0]     w_acc_next;
    logic             w_carry;

    assign w_hs         = (r_state == S_RUN) && bus.op_valid;
    assign w_last       = w_hs && (r_remaining == LEN_W'(1));
    // The acc_out stage is excluded: its add lands on the same edge that
    // leaves DRAIN, so the result is complete on entry to DONE.
    assign w_pipe_empty = ~|r_tag_valid[MAC_LAT-1:0];

`ifdef DOTP_SAT_EN
    logic [128:0] w_sum;
    assign w_sum      = {1'b0, r_acc} + {1'b0, bus.mac_acc_out};
    assign w_carry    = w_sum[128];
    assign w_acc_next = w_sum[128] ? {128{1'b1}} : w_sum[127:0];
`else
    assign w_carry    = 1'b0;
    assign w_acc_next = r_acc + bus.mac_acc_out;
`endif

    // Control FSM, command latching and accumulation of returned MAC values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_bias          <= '0;
            r_acc           <= '0;
            r_ovf           <= 1'b0;
            r_first_pending <= 1'b0;
        end else begin
            if (r_tag_valid[MAC_LAT]) begin
                r_acc <= w_acc_next;
                if (w_carry) begin
                    r_ovf <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bias <= bus.bias;
                        r_ovf  <= 1'b0;
                        if (bus.len == '0) begin
                            // Empty vector: the result is just the bias.
                            r_acc   <= {64'd0, bus.bias};
                            r_state <= S_DONE;
                        end else begin
                            r_acc           <= '0;
                            r_remaining     <= bus.len;
                            r_first_pending <= 1'b1;
                            r_state         <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_remaining     <= r_remaining - LEN_W'(1);
                        r_first_pending <= 1'b0;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Operand issue registers and the tag pipeline that shadows the MAC.
    // Bubbles issue zeros with an invalid tag so they are never summed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_tag_valid <= '0;
            r_tag_first <= '0;
        end else begin
            r_mac_a     <= w_hs ? bus.op_a : 64'd0;
            r_mac_b     <= w_hs ? bus.op_b : 64'd0;
            r_tag_valid <= {r_tag_valid[MAC_LAT-1:0], w_hs};
            r_tag_first <= {r_tag_first[MAC_LAT-1:0], w_hs && r_first_pending};
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.op_ready   = (r_state == S_RUN);
    assign bus.mac_a      = r_mac_a;
    assign bus.mac_b      = r_mac_b;
    // The bias joins the add stage alongside the product of the first pair.
    assign bus.mac_acc_in = r_tag_first[1] ? r_bias : 64'd0;
    assign bus.res_valid  = (r_state == S_DONE);
    assign bus.res_data   = r_acc;
    assign bus.res_ovf    = r_ovf;

endmodule

// File: tb/tb_dotp_seq.sv
// ---------------------------------------------------------------------------
// tb_dotp_seq
// Directed testbench for dotp_seq with a behavioural three-stage MAC
// (product, add acc_in, output register) attached to the MAC side.
// Build option DOTP_SAT_EN selects the saturating expectations.
// ---------------------------------------------------------------------------
module tb_dotp_seq;

    logic clk = 1'b0;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;
    int   accInCount  = 0;
    int   macACount   = 0;
    logic [63:0] accInValue = '0;

    dotp_if #(.LEN_W(16)) bus ();

    dotp_seq #(.LEN_W(16), .MAC_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural MAC; deliberately not reset so stale in-flight values
    // still emerge after a sequencer reset.
    logic [127:0] macProd = '0;
    logic [127:0] macSum  = '0;
    logic [127:0] macOut  = '0;
    always @(posedge clk) begin
        macProd <= {64'd0, bus.mac_a} * {64'd0, bus.mac_b};
        macSum  <= macProd + {64'd0, bus.mac_acc_in};
        macOut  <= macSum;
    end
    assign bus.mac_acc_out = macOut;

    // Advance to the next falling edge and record MAC-side activity.
    task automatic tick;
        @(negedge clk);
        if (bus.mac_acc_in != 64'd0) begin
            accInCount++;
            accInValue = bus.mac_acc_in;
        end
        if (bus.mac_a != 64'd0) macACount++;
    endtask

    task automatic applyStimulus(input logic [15:0] len, input logic [63:0] bias);
        bus.start = 1'b1;
        bus.len   = len;
        bus.bias  = bias;
        tick();
        bus.start = 1'b0;
        bus.len   = 16'hDEAD;
        bus.bias  = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic waitResult(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic releaseResult;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        assertCount++;
        if (bus.op_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_op_ready: got %b expected 0", bus.op_ready); end
        assertCount++;
        if (bus.mac_a !== 64'd0 || bus.mac_b !== 64'd0) begin failCount++; $display("[TB] FAIL reset_mac_ab: got %0h/%0h expected 0/0", bus.mac_a, bus.mac_b); end
        assertCount++;
        if (bus.mac_acc_in !== 64'd0) begin failCount++; $display("[TB] FAIL reset_acc_in: got %0h expected 0", bus.mac_acc_in); end
        assertCount++;
        if (bus.res_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        assertCount++;
        if (bus.res_data !== 128'd0) begin failCount++; $display("[TB] FAIL reset_res_data: got %0h expected 0", bus.res_data); end
        assertCount++;
        if (bus.res_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_res_ovf: got %b expected 0", bus.res_ovf); end
    endtask

    task automatic test_basic;
        logic [63:0] pa [3] = '{64'd2, 64'd4, 64'd6};
        logic [63:0] pb [3] = '{64'd3, 64'd5, 64'd7};
        int n;
        accInCount = 0;
        applyStimulus(16'd3, 64'd10);
        assertCount++;
        if (bus.busy !== 1'b1 || bus.op_ready !== 1'b1) begin failCount++; $display("[TB] FAIL basic_start: got busy=%b op_ready=%b expected 1/1", bus.busy, bus.op_ready); end
        for (int i = 0; i < 3; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = pa[i];
            bus.op_b = pb[i];
            tick();
        end
        bus.op_valid = 1'b0;
        assertCount++;
        if (bus.op_ready !== 1'b0) begin failCount++; $display("[TB] FAIL basic_ready_drop: got %b expected 0", bus.op_ready); end
        waitResult(n);
        assertCount++;
        if (n + 1 != 5) begin failCount++; $display("[TB] FAIL basic_latency: got %0d expected 5", n + 1); end
        assertCount++;
        if (bus.res_data !== 128'd78) begin failCount++; $display("[TB] FAIL basic_sum: got %0d expected 78", bus.res_data); end
        assertCount++;
        if (accInCount != 1 || accInValue !== 64'd10) begin failCount++; $display("[TB] FAIL basic_acc_in: got %0d cycles value %0d expected 1 cycle value 10", accInCount, accInValue); end
        releaseResult();
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic_idle: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_len_zero;
        macACount = 0;
        applyStimulus(16'd0, 64'hFFFF);
        assertCount++;
        if (bus.res_valid !== 1'b1) begin failCount++; $display("[TB] FAIL zero_valid: got %b expected 1", bus.res_valid); end
        assertCount++;
        if (bus.res_data !== 128'hFFFF) begin failCount++; $display("[TB] FAIL zero_data: got %0h expected ffff", bus.res_data); end
        releaseResult();
        tick();
        assertCount++;
        if (macACount != 0) begin failCount++; $display("[TB] FAIL zero_mac_a: got %0d active cycles expected 0", macACount); end
    endtask

    task automatic test_toggle;
        int n;
        int hs = 0;
        logic readyBad = 1'b0;
        macACount = 0;
        applyStimulus(16'd4, 64'd5);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                bus.op_valid = 1'b1;
                bus.op_a = 64'(k + 1);
                bus.op_b = 64'(k + 2);
            end else begin
                bus.op_valid = 1'b0;
                bus.op_a = 64'd99;
                bus.op_b = 64'd99;
            end
            if (k < 7 && bus.op_ready !== 1'b1) readyBad = 1'b1;
            if (bus.op_valid && bus.op_ready === 1'b1) hs++;
            tick();
        end
        bus.op_valid = 1'b0;
        assertCount++;
        if (readyBad !== 1'b0) begin failCount++; $display("[TB] FAIL toggle_ready: got unsteady op_ready expected steady high"); end
        assertCount++;
        if (hs != 4) begin failCount++; $display("[TB] FAIL toggle_handshakes: got %0d expected 4", hs); end
        waitResult(n);
        assertCount++;
        if (bus.res_data !== 128'd105) begin failCount++; $display("[TB] FAIL toggle_sum: got %0d expected 105", bus.res_data); end
        assertCount++;
        if (macACount != 4) begin failCount++; $display("[TB] FAIL toggle_issues: got %0d expected 4", macACount); end
        releaseResult();
    endtask

    task automatic test_back_to_back;
        int n;
        logic stableBad = 1'b0;
        applyStimulus(16'd2, 64'd1);
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = (i == 0) ? 64'd3 : 64'd5;
            bus.op_b = (i == 0) ? 64'd4 : 64'd6;
            tick();
        end
        bus.op_valid = 1'b0;
        waitResult(n);
        for (int i = 0; i < 10; i++) begin
            bus.start = (i % 2 == 0);
            bus.len   = 16'd0;
            bus.bias  = 64'd77;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 128'd43) stableBad = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        assertCount++;
        if (stableBad !== 1'b0) begin failCount++; $display("[TB] FAIL bp_stable: got %0d/%b expected 43 held", bus.res_data, bus.res_valid); end
        assertCount++;
        if (bus.res_data !== 128'd43) begin failCount++; $display("[TB] FAIL bp_sum: got %0d expected 43", bus.res_data); end
        releaseResult();
        assertCount++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_idle: got busy=%b valid=%b expected 0/0", bus.busy, bus.res_valid); end
        applyStimulus(16'd0, 64'd3);
        assertCount++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 128'd3) begin failCount++; $display("[TB] FAIL bp_next_start: got %0d/%b expected 3/1", bus.res_data, bus.res_valid); end
        releaseResult();
    endtask

    task automatic test_reset_midrun;
        int n;
        applyStimulus(16'd5, 64'd50);
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = 64'd10 + 64'(i);
            bus.op_b = 64'd10;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        assertCount++;
        if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_ctrl: got busy=%b ready=%b valid=%b expected 0/0/0", bus.busy, bus.op_ready, bus.res_valid); end
        assertCount++;
        if (bus.mac_a !== 64'd0 || bus.mac_b !== 64'd0 || bus.mac_acc_in !== 64'd0 || bus.res_data !== 128'd0) begin failCount++; $display("[TB] FAIL midrst_data: got a=%0h b=%0h accin=%0h res=%0h expected all 0", bus.mac_a, bus.mac_b, bus.mac_acc_in, bus.res_data); end
        @(negedge clk);
        rst = 1'b0;
        bus.op_valid = 1'b0;
        applyStimulus(16'd1, 64'd0);
        bus.op_valid = 1'b1;
        bus.op_a = 64'd3;
        bus.op_b = 64'd3;
        tick();
        bus.op_valid = 1'b0;
        waitResult(n);
        assertCount++;
        if (bus.res_data !== 128'd9) begin failCount++; $display("[TB] FAIL midrst_result: got %0d expected 9", bus.res_data); end
        releaseResult();
    endtask

    task automatic test_saturation;
        int n;
        logic [127:0] expData;
        logic         expOvf;
`ifdef DOTP_SAT_EN
        expData = {128{1'b1}};
        expOvf  = 1'b1;
`else
        expData = 128'hFFFFFFFFFFFFFFFC_8000000000000002;
        expOvf  = 1'b0;
`endif
        applyStimulus(16'd2, 64'h8000_0000_0000_0000);
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = {64{1'b1}};
            bus.op_b = {64{1'b1}};
            tick();
        end
        bus.op_valid = 1'b0;
        waitResult(n);
        assertCount++;
        if (bus.res_data !== expData) begin failCount++; $display("[TB] FAIL sat_data: got %0h expected %0h", bus.res_data, expData); end
        assertCount++;
        if (bus.res_ovf !== expOvf) begin failCount++; $display("[TB] FAIL sat_ovf: got %b expected %b", bus.res_ovf, expOvf); end
        releaseResult();
        applyStimulus(16'd0, 64'd1);
        assertCount++;
        if (bus.res_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL sat_ovf_clear: got %b expected 0", bus.res_ovf); end
        releaseResult();
    endtask

    // Scenario sequence.
    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_len_zero();
        test_toggle();
        test_back_to_back();
        test_reset_midrun();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
